// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared types and widths for the AGC gain sequencer
// Contents: sequencer state enum, gain/control/thermometer widths.
package agc_pkg;

  localparam int GAIN_W     = 6;
  localparam int VGA_CTRL_W = 64;
  localparam int THERM_W    = 63;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } agc_state_t;

endpackage

// File: rtl/gain_thermometer.sv
// rtl/gain_thermometer.sv - binary gain code to thermometer code
// Ports:
//   gain  in  [5:0]  gain code 0..63
//   therm out [62:0] therm[i] = (i < gain)
module gain_thermometer
  import agc_pkg::*;
(
  input  logic [GAIN_W-1:0]  gain,
  output logic [THERM_W-1:0] therm
);

  always_comb begin
    therm = '0;
    for (int i = 0; i < THERM_W; i++) begin
      therm[i] = (GAIN_W'(i) < gain);
    end
  end

endmodule

// File: rtl/vga_gain_sequencer.sv
// rtl/vga_gain_sequencer.sv - VGA gain ramp / settle / lock sequencer
// Ports:
//   clk          in        rising-edge clock
//   RESETn       in        synchronous active-low reset
//   gain_in      in  [5:0] requested gain from the AGC search
//   gain_valid   in        strobe qualifying gain_in
//   agc_done     in        AGC search complete (level)
//   relock       in        strobe leaving LOCKED
//   vga_control  out [63:0] [62:0] thermometer of cur_gain, [63] lock flag
//   cur_gain     out [5:0] applied gain
//   busy         out       RAMP or SETTLE
//   settled      out       one-cycle pulse at settle expiry
//   locked       out       in LOCKED
// Build option: define VGA_GAIN_RAMP_EN to step the gain 1 LSB every
// STEP_DIV cycles; otherwise an accepted gain is applied on the next edge.
module vga_gain_sequencer
  import agc_pkg::*;
#(
  parameter int unsigned       STEP_DIV      = 2,
  parameter int unsigned       SETTLE_CYCLES = 16,
  parameter logic [GAIN_W-1:0] RESET_GAIN    = 6'd32
) (
  input  logic                  clk,
  input  logic                  RESETn,
  input  logic [GAIN_W-1:0]     gain_in,
  input  logic                  gain_valid,
  input  logic                  agc_done,
  input  logic                  relock,
  output logic [VGA_CTRL_W-1:0] vga_control,
  output logic [GAIN_W-1:0]     cur_gain,
  output logic                  busy,
  output logic                  settled,
  output logic                  locked
);

  if (STEP_DIV < 1 || STEP_DIV > 15) begin : g_bad_step_div
    $error("STEP_DIV must be 1..15");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 1..255");
  end

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  agc_state_t        state_q, state_d;
  logic [GAIN_W-1:0] gain_d;
  logic [7:0]        settle_q, settle_d;
  logic              done_pend_q, done_pend_d;
  logic              settled_d;
  logic              busy_d, locked_d;
  logic [GAIN_W-1:0] therm_gain;
  logic [THERM_W-1:0] therm;

`ifdef VGA_GAIN_RAMP_EN
  localparam logic [3:0] STEP_LAST = 4'(STEP_DIV - 1);
  logic [GAIN_W-1:0] target_q, target_d;
  logic [3:0]        step_q, step_d;
  logic [GAIN_W-1:0] ramp_tgt;
  logic [GAIN_W-1:0] ramp_next;

  // A retarget takes effect on the same edge it is presented.
  assign ramp_tgt  = gain_valid ? gain_in : target_q;
  assign ramp_next = (ramp_tgt > cur_gain) ? cur_gain + 6'd1 : cur_gain - 6'd1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      cur_gain    <= RESET_GAIN;
      settle_q    <= '0;
      done_pend_q <= 1'b0;
`ifdef VGA_GAIN_RAMP_EN
      target_q    <= RESET_GAIN;
      step_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_gain    <= gain_d;
      settle_q    <= settle_d;
      done_pend_q <= done_pend_d;
`ifdef VGA_GAIN_RAMP_EN
      target_q    <= target_d;
      step_q      <= step_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    gain_d    = cur_gain;
    settle_d  = settle_q;
    settled_d = 1'b0;
`ifdef VGA_GAIN_RAMP_EN
    target_d  = target_q;
    step_d    = step_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (done_pend_q || agc_done) begin
          state_d = ST_LOCKED;
        end else if (gain_valid) begin
          settle_d = '0;
`ifdef VGA_GAIN_RAMP_EN
          target_d = gain_in;
          step_d   = '0;
          state_d  = (gain_in != cur_gain) ? ST_RAMP : ST_SETTLE;
`else
          gain_d   = gain_in;
          state_d  = ST_SETTLE;
`endif
        end
      end
`ifdef VGA_GAIN_RAMP_EN
      ST_RAMP: begin
        target_d = ramp_tgt;
        if (cur_gain == ramp_tgt) begin
          // Retarget onto the current gain: nothing left to step.
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else if (step_q == STEP_LAST) begin
          step_d = '0;
          gain_d = ramp_next;
          if (ramp_next == ramp_tgt) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
          end
        end else begin
          step_d = step_q + 4'd1;
        end
      end
`endif
      ST_SETTLE: begin
        if (gain_valid) begin
          settle_d = '0;
`ifdef VGA_GAIN_RAMP_EN
          target_d = gain_in;
          if (gain_in != cur_gain) state_d = ST_RAMP;
`else
          gain_d   = gain_in;
`endif
        end else if (settle_q == SETTLE_LAST) begin
          settled_d = 1'b1;
          settle_d  = '0;
          state_d   = done_pend_q ? ST_LOCKED : ST_IDLE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_LOCKED: begin
        if (relock) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // relock beats agc_done; entering LOCKED consumes the pending request.
    done_pend_d = done_pend_q;
    if (relock) begin
      done_pend_d = 1'b0;
    end else if (state_d == ST_LOCKED && state_q != ST_LOCKED) begin
      done_pend_d = 1'b0;
    end else if (agc_done && state_q != ST_LOCKED) begin
      done_pend_d = 1'b1;
    end
  end

  // Output decode; registered below so outputs line up with the new state.
  always_comb begin
    busy_d     = (state_d == ST_RAMP) || (state_d == ST_SETTLE);
    locked_d   = (state_d == ST_LOCKED);
    therm_gain = RESETn ? gain_d : RESET_GAIN;
  end

  gain_thermometer u_therm (
    .gain  (therm_gain),
    .therm (therm)
  );

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      busy        <= 1'b0;
      settled     <= 1'b0;
      locked      <= 1'b0;
      vga_control <= {1'b0, therm};
    end else begin
      busy        <= busy_d;
      settled     <= settled_d;
      locked      <= locked_d;
      vga_control <= {locked_d, therm};
    end
  end

endmodule

// File: tb/tb_vga_gain_sequencer.sv
// tb/tb_vga_gain_sequencer.sv - scoreboard bench for vga_gain_sequencer
module tb_vga_gain_sequencer;

  localparam int          STEP_DIV      = 2;
  localparam int          SETTLE_CYCLES = 16;
  localparam logic [5:0]  RESET_GAIN    = 6'd32;

  localparam int M_IDLE = 0, M_RAMP = 1, M_SETTLE = 2, M_LOCK = 3;

  logic        clk = 1'b0;
  logic        RESETn = 1'b0;
  logic [5:0]  gain_in = '0;
  logic        gain_valid = 1'b0;
  logic        agc_done = 1'b0;
  logic        relock = 1'b0;
  logic [63:0] vga_control;
  logic [5:0]  cur_gain;
  logic        busy, settled, locked;

  typedef struct packed {
    logic [5:0]  g;
    logic        b;
    logic        s;
    logic        l;
    logic [63:0] v;
  } snap_t;

  snap_t      exp_q[$];
  logic [5:0] settle_q[$];

  int checks = 0;
  int failures = 0;
  int settled_seen = 0;

  // Reference model state
  int         m_mode = M_IDLE;
  int         m_gain = 32;
  int         m_target = 32;
  int         m_step_left = STEP_DIV;
  int         m_settle_left = SETTLE_CYCLES;
  bit         m_pend = 0;

  vga_gain_sequencer #(
    .STEP_DIV      (STEP_DIV),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .RESET_GAIN    (RESET_GAIN)
  ) dut (
    .clk         (clk),
    .RESETn      (RESETn),
    .gain_in     (gain_in),
    .gain_valid  (gain_valid),
    .agc_done    (agc_done),
    .relock      (relock),
    .vga_control (vga_control),
    .cur_gain    (cur_gain),
    .busy        (busy),
    .settled     (settled),
    .locked      (locked)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [63:0] expect_vga(input int g, input bit lk);
    logic [63:0] ones;
    ones = (64'd1 << g) - 64'd1;
    return {lk, ones[62:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rn, input bit gv, input int gi, input bit ad, input bit rl);
    int  prev;
    bit  pulse;
    snap_t e;
    pulse = 0;
    if (!rn) begin
      m_mode = M_IDLE; m_gain = RESET_GAIN; m_target = RESET_GAIN;
      m_step_left = STEP_DIV; m_settle_left = SETTLE_CYCLES; m_pend = 0;
    end else begin
      prev = m_mode;
      case (m_mode)
        M_IDLE: begin
          if (m_pend || ad) m_mode = M_LOCK;
          else if (gv) begin
            m_target = gi; m_settle_left = SETTLE_CYCLES; m_step_left = STEP_DIV;
`ifdef VGA_GAIN_RAMP_EN
            m_mode = (gi != m_gain) ? M_RAMP : M_SETTLE;
`else
            m_gain = gi; m_mode = M_SETTLE;
`endif
          end
        end
        M_RAMP: begin
          if (gv) m_target = gi;
          if (m_gain == m_target) begin
            m_mode = M_SETTLE; m_settle_left = SETTLE_CYCLES;
          end else begin
            m_step_left--;
            if (m_step_left == 0) begin
              m_step_left = STEP_DIV;
              m_gain += (m_target > m_gain) ? 1 : -1;
              if (m_gain == m_target) begin
                m_mode = M_SETTLE; m_settle_left = SETTLE_CYCLES;
              end
            end
          end
        end
        M_SETTLE: begin
          if (gv) begin
            m_target = gi; m_settle_left = SETTLE_CYCLES;
`ifdef VGA_GAIN_RAMP_EN
            if (gi != m_gain) m_mode = M_RAMP;
`else
            m_gain = gi;
`endif
          end else begin
            m_settle_left--;
            if (m_settle_left == 0) begin
              pulse = 1;
              m_settle_left = SETTLE_CYCLES;
              m_mode = m_pend ? M_LOCK : M_IDLE;
            end
          end
        end
        default: if (rl) m_mode = M_IDLE;
      endcase
      if (rl) m_pend = 0;
      else if (m_mode == M_LOCK && prev != M_LOCK) m_pend = 0;
      else if (ad && prev != M_LOCK) m_pend = 1;
    end
    if (m_gain < 0 || m_gain > 63) begin
      checks++; failures++;
      $display("FAIL model_range: gain %0d", m_gain);
    end
    e.g = 6'(m_gain);
    e.b = (m_mode == M_RAMP) || (m_mode == M_SETTLE);
    e.s = pulse;
    e.l = (m_mode == M_LOCK);
    e.v = expect_vga(m_gain, m_mode == M_LOCK);
    exp_q.push_back(e);
    if (pulse) settle_q.push_back(6'(m_gain));
  endtask

  task automatic cycle(input bit rn, input bit gv, input logic [5:0] gi, input bit ad, input bit rl);
    RESETn = rn; gain_valid = gv; gain_in = gi; agc_done = ad; relock = rl;
    @(posedge clk);
    model_step(rn, gv, int'(gi), ad, rl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 6'd0, 0, 0);
  endtask

  task automatic wait_settled(input string name, input int maxc, output int n);
    n = 0;
    while (settled !== 1'b1 && n < maxc) begin
      cycle(1, 0, 6'd0, 0, 0);
      n++;
    end
    chk({name, "_settled_seen"}, {63'd0, settled}, 64'd1);
  endtask

  // Monitor: pops the expected snapshot for every clock and the expected
  // gain for every settled pulse.
  initial forever begin
    snap_t e, a;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {cur_gain, busy, settled, locked, vga_control};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t: gain %0d/%0d busy %b/%b settled %b/%b locked %b/%b vga %h/%h",
                 $time, a.g, e.g, a.b, e.b, a.s, e.s, a.l, e.l, a.v, e.v);
      end
    end
    if (settled === 1'b1) begin
      settled_seen++;
      checks++;
      if (settle_q.size() == 0) begin
        failures++;
        $display("FAIL settled_spurious t=%0t: gain %0d", $time, cur_gain);
      end else begin
        logic [5:0] eg;
        eg = settle_q.pop_front();
        if (cur_gain !== eg) begin
          failures++;
          $display("FAIL settled_gain t=%0t: got %0d expected %0d", $time, cur_gain, eg);
        end
      end
    end
  end

  initial begin
    int n, s0;
    bit ad_lvl;
    bit rl, gv, rn;
    logic [5:0] gi;

    cycle(0, 0, 6'd0, 0, 0);
    cycle(0, 0, 6'd0, 0, 0);
    chk("reset_gain", 64'(cur_gain), 64'd32);
    chk("reset_vga", vga_control, 64'h0000_0000_FFFF_FFFF);
    chk("reset_status", {61'd0, busy, settled, locked}, 64'd0);

    // Ramp up 32 -> 40
    cycle(1, 1, 6'd40, 0, 0);
`ifdef VGA_GAIN_RAMP_EN
    idle(15);
    chk("ramp_gain_e15", 64'(cur_gain), 64'd39);
    idle(1);
`endif
    chk("up_gain", 64'(cur_gain), 64'd40);
    chk("up_busy", {63'd0, busy}, 64'd1);
    wait_settled("up", 100, n);
    chk("up_settle_delay", 64'(n), 64'(SETTLE_CYCLES));
    chk("up_vga", vga_control, 64'h0000_00FF_FFFF_FFFF);

    // Extremes
    cycle(1, 1, 6'd0, 0, 0);
    wait_settled("zero", 400, n);
    chk("zero_vga", {1'b0, vga_control[62:0]}, 64'd0);
    cycle(1, 1, 6'd63, 0, 0);
`ifndef VGA_GAIN_RAMP_EN
    chk("max_applied_next_edge", 64'(cur_gain), 64'd63);
`endif
    wait_settled("max", 400, n);
    chk("max_vga", {1'b0, vga_control[62:0]}, 64'h7FFF_FFFF_FFFF_FFFF);

    // Lock: agc_done during busy, lock only at settle expiry
    cycle(1, 1, 6'd40, 0, 0);
    cycle(1, 0, 6'd0, 1, 0);
    chk("lock_not_yet", {63'd0, locked}, 64'd0);
    wait_settled("lock", 400, n);
    chk("lock_locked", {63'd0, locked}, 64'd1);
    chk("lock_flag", {63'd0, vga_control[63]}, 64'd1);
    cycle(1, 1, 6'd10, 0, 0);
    chk("lock_frozen", 64'(cur_gain), 64'd40);

    // Relock together with agc_done
    cycle(1, 0, 6'd0, 1, 1);
    chk("relock_locked", {62'd0, locked, busy}, 64'd0);
    idle(4);
    chk("relock_pend_clear", {63'd0, locked}, 64'd0);

    // Reset in the middle of an operation
    cycle(1, 1, 6'd50, 0, 0);
    idle(3);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    cycle(0, 0, 6'd0, 0, 0);
    chk("mid_reset_gain", 64'(cur_gain), 64'd32);
    chk("mid_reset_status", {61'd0, busy, settled, locked}, 64'd0);
    s0 = settled_seen;
    idle(30);
    chk("mid_reset_no_pulse", 64'(settled_seen - s0), 64'd0);

    // Retarget downward during the ramp
    cycle(1, 1, 6'd40, 0, 0);
`ifdef VGA_GAIN_RAMP_EN
    idle(6);
    chk("retarget_at35", 64'(cur_gain), 64'd35);
`endif
    cycle(1, 1, 6'd30, 0, 0);
    s0 = settled_seen;
    wait_settled("retarget", 400, n);
    chk("retarget_gain", 64'(cur_gain), 64'd30);
    idle(20);
    chk("retarget_single_pulse", 64'(settled_seen - s0), 64'd1);

    // Randomised traffic
    ad_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 79) == 0) ad_lvl = ~ad_lvl;
      gv = ($urandom_range(0, 23) == 0);
      case ($urandom_range(0, 7))
        0: gi = 6'd0;
        1: gi = 6'd63;
        default: gi = 6'($urandom_range(0, 63));
      endcase
      rl = ($urandom_range(0, 29) == 0);
      rn = ($urandom_range(0, 399) != 0);
      cycle(rn, gv, gi, ad_lvl, rl);
    end
    idle(200);
    @(negedge clk);
    @(negedge clk);
    chk("settle_queue_drained", 64'(settle_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
